// File: rtl/io_pulse_stretcher_if.sv
// io_pulse_stretcher_if
// Groups the event/pulse signals of io_pulse_stretcher.
//   i_trig     event request from core logic (one event per rising edge)
//   o_pin      stretched pulse towards the pad
//   o_busy     stretcher is emitting a pulse or its trailing gap
//   o_pending  queued events not yet emitted
//   i_ovf_clr  clears o_ovf              (only with IO_PULSE_OVF_EN)
//   o_ovf      sticky event-dropped flag (only with IO_PULSE_OVF_EN)
// Modports: master = core side, slave = stretcher side.
interface io_pulse_stretcher_if #(
    parameter int unsigned PARAM_PEND_W = 4
);
    logic                    i_trig;
    logic                    o_pin;
    logic                    o_busy;
    logic [PARAM_PEND_W-1:0] o_pending;
`ifdef IO_PULSE_OVF_EN
    logic                    i_ovf_clr;
    logic                    o_ovf;

    modport master (
        output i_trig,
        output i_ovf_clr,
        input  o_pin,
        input  o_busy,
        input  o_pending,
        input  o_ovf
    );

    modport slave (
        input  i_trig,
        input  i_ovf_clr,
        output o_pin,
        output o_busy,
        output o_pending,
        output o_ovf
    );
`else
    modport master (
        output i_trig,
        input  o_pin,
        input  o_busy,
        input  o_pending
    );

    modport slave (
        input  i_trig,
        output o_pin,
        output o_busy,
        output o_pending
    );
`endif
endinterface

// File: rtl/io_pulse_stretcher.sv
// io_pulse_stretcher
// Converts single-cycle event strobes into pad-visible pulses with a guaranteed
// high time and a guaranteed low gap. Events arriving while a pulse is active
// are queued in a saturating counter and replayed back to back.
// Ports:
//   i_clk  system clock
//   i_rst  asynchronous, active-high reset
//   bus    io_pulse_stretcher_if.slave: i_trig in; o_pin, o_busy, o_pending out
//          (plus i_ovf_clr in, o_ovf out when IO_PULSE_OVF_EN is defined)
// Optional feature: define IO_PULSE_OVF_EN to get a sticky overflow flag that
// records events dropped at counter saturation.
module io_pulse_stretcher #(
    parameter int unsigned PARAM_FREQ    = 10000000,
    parameter int unsigned PARAM_HOLD_MS = 10,
    parameter int unsigned PARAM_GAP_MS  = 10,
    parameter int unsigned PARAM_PEND_W  = 4
) (
    input logic                 i_clk,
    input logic                 i_rst,
    io_pulse_stretcher_if.slave bus
);

    localparam int unsigned CycPerMs = PARAM_FREQ / 1000;
    localparam int unsigned HoldRaw  = CycPerMs * PARAM_HOLD_MS;
    localparam logic [31:0] HoldCyc  = (HoldRaw == 0) ? 32'd1 : HoldRaw;
    localparam logic [31:0] GapCyc   = CycPerMs * PARAM_GAP_MS;

    localparam logic [PARAM_PEND_W-1:0] PendMax = '1;
    localparam logic [PARAM_PEND_W-1:0] PendOne = PARAM_PEND_W'(1);

    typedef enum logic [1:0] {StIdle, StHold, StGap} state_e;

    state_e                  state_q, state_d;
    logic [31:0]             timer_q, timer_d;
    logic [PARAM_PEND_W-1:0] pend_q, pend_d;
    logic                    trig_d_q;
    logic                    pin_q;
    logic                    busy_q;
    logic                    ev;
    logic                    end_cycle;
    logic                    drop;

    always_comb begin
        ev        = bus.i_trig & ~trig_d_q;
        state_d   = state_q;
        timer_d   = timer_q;
        pend_d    = pend_q;
        end_cycle = 1'b0;
        drop      = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (ev) begin
                    state_d = StHold;
                    timer_d = 32'd0;
                end
            end
            StHold: begin
                if (timer_q == HoldCyc - 32'd1) begin
                    if (GapCyc != 32'd0) begin
                        state_d = StGap;
                        timer_d = 32'd0;
                    end else begin
                        end_cycle = 1'b1;
                    end
                end else begin
                    timer_d = timer_q + 32'd1;
                end
            end
            StGap: begin
                if (timer_q == GapCyc - 32'd1) begin
                    end_cycle = 1'b1;
                end else begin
                    timer_d = timer_q + 32'd1;
                end
            end
            default: state_d = StIdle;
        endcase

        // Expiry decision: replay a queued event, or start on a coincident event
        // (counted then immediately dequeued), otherwise fall back to idle.
        if (end_cycle) begin
            if (pend_q != '0) begin
                state_d = StHold;
                timer_d = 32'd0;
                // A same-cycle event replaces the dequeued one, even when saturated.
                if (!ev) begin
                    pend_d = pend_q - PendOne;
                end
            end else if (ev) begin
                state_d = StHold;
                timer_d = 32'd0;
            end else begin
                state_d = StIdle;
            end
        end else if (ev && (state_q != StIdle)) begin
            if (pend_q != PendMax) begin
                pend_d = pend_q + PendOne;
            end else begin
                drop = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q  <= StIdle;
            timer_q  <= 32'd0;
            pend_q   <= '0;
            trig_d_q <= 1'b0;
            pin_q    <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            pend_q   <= pend_d;
            trig_d_q <= bus.i_trig;
            // Outputs follow the next state so the pin rises on the event edge.
            pin_q    <= (state_d == StHold);
            busy_q   <= (state_d != StIdle);
        end
    end

    assign bus.o_pin     = pin_q;
    assign bus.o_busy    = busy_q;
    assign bus.o_pending = pend_q;

`ifdef IO_PULSE_OVF_EN
    logic ovf_q;

    // Set has priority over clear.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= drop | (ovf_q & ~bus.i_ovf_clr);
        end
    end

    assign bus.o_ovf = ovf_q;
`else
    logic unused_drop;
    assign unused_drop = drop;
`endif

endmodule

// File: tb/tb_io_pulse_stretcher.sv
// Bench for io_pulse_stretcher: table-driven vectors, hand-written corner
// sequences and a randomized run against a schedule-based reference model.
module tb_io_pulse_stretcher;

    localparam int H        = 100;
    localparam int G        = 100;
    localparam int PendMaxA = 15;

    typedef struct {
        logic rst;
        logic trig;
        int   cyc;
        logic pin;
        logic busy;
        int   pend;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    vec_t vecs[$];
    // Reference model: start cycle of every accepted pulse.
    int   starts[$];
    int   last_start;
    int   n_edge;
    logic prev_trig;

    int   hi_cnt;
    int   fall_cnt;
    int   rise_cnt;
    logic last_pin;
    logic t_rand;
    logic r_rand;

    io_pulse_stretcher_if #(.PARAM_PEND_W(4)) bus_a ();
    io_pulse_stretcher_if #(.PARAM_PEND_W(2)) bus_b ();
    io_pulse_stretcher_if #(.PARAM_PEND_W(4)) bus_c ();

    io_pulse_stretcher #(
        .PARAM_FREQ(100000), .PARAM_HOLD_MS(1), .PARAM_GAP_MS(1), .PARAM_PEND_W(4)
    ) u_dut_a (.i_clk(clk), .i_rst(rst), .bus(bus_a));

    io_pulse_stretcher #(
        .PARAM_FREQ(100000), .PARAM_HOLD_MS(1), .PARAM_GAP_MS(1), .PARAM_PEND_W(2)
    ) u_dut_b (.i_clk(clk), .i_rst(rst), .bus(bus_b));

    io_pulse_stretcher #(
        .PARAM_FREQ(100000), .PARAM_HOLD_MS(1), .PARAM_GAP_MS(0), .PARAM_PEND_W(4)
    ) u_dut_c (.i_clk(clk), .i_rst(rst), .bus(bus_c));

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0d, want %0d", name, act, req);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int cnt_after(input int n);
        int c = 0;
        foreach (starts[i]) if (starts[i] > n) c++;
        return c;
    endfunction

    function automatic logic exp_on(input int n, input int len);
        foreach (starts[i]) if (starts[i] <= n && n < starts[i] + len) return 1'b1;
        return 1'b0;
    endfunction

    // A new event is accepted while fewer than PendMaxA pulses are still
    // waiting to start; it starts at the later of now and the end of the last
    // scheduled pulse plus gap.
    task automatic model_edge(input logic r, input logic t);
        int s;
        if (r) begin
            starts.delete();
            last_start = -1000000;
            prev_trig  = 1'b0;
        end else begin
            if (t && !prev_trig && cnt_after(n_edge) < PendMaxA) begin
                s = (last_start + H + G > n_edge) ? last_start + H + G : n_edge;
                starts.push_back(s);
                last_start = s;
            end
            prev_trig = t;
            while (starts.size() > 0 && starts[0] + H + G <= n_edge) void'(starts.pop_front());
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst          = 1'b1;
        bus_a.i_trig = 1'b0;
        bus_b.i_trig = 1'b0;
        bus_c.i_trig = 1'b0;
`ifdef IO_PULSE_OVF_EN
        bus_a.i_ovf_clr = 1'b0;
        bus_b.i_ovf_clr = 1'b0;
        bus_c.i_ovf_clr = 1'b0;
`endif

        // {rst, trig, edges to advance, pin, busy, pending}
        vecs.push_back('{1'b1, 1'b0, 2, 1'b0, 1'b0, 0});
        vecs.push_back('{1'b0, 1'b0, 1, 1'b0, 1'b0, 0});
        // single strobe
        vecs.push_back('{1'b0, 1'b1, 1, 1'b1, 1'b1, 0});
        vecs.push_back('{1'b0, 1'b0, 99, 1'b1, 1'b1, 0});
        vecs.push_back('{1'b0, 1'b0, 1, 1'b0, 1'b1, 0});
        vecs.push_back('{1'b0, 1'b0, 99, 1'b0, 1'b1, 0});
        vecs.push_back('{1'b0, 1'b0, 1, 1'b0, 1'b0, 0});
        // trigger held for 500 cycles
        vecs.push_back('{1'b0, 1'b1, 1, 1'b1, 1'b1, 0});
        vecs.push_back('{1'b0, 1'b1, 99, 1'b1, 1'b1, 0});
        vecs.push_back('{1'b0, 1'b1, 1, 1'b0, 1'b1, 0});
        vecs.push_back('{1'b0, 1'b1, 99, 1'b0, 1'b1, 0});
        vecs.push_back('{1'b0, 1'b1, 1, 1'b0, 1'b0, 0});
        vecs.push_back('{1'b0, 1'b1, 299, 1'b0, 1'b0, 0});
        vecs.push_back('{1'b0, 1'b0, 1, 1'b0, 1'b0, 0});
        // strobes at 0, 10, 20
        vecs.push_back('{1'b0, 1'b1, 1, 1'b1, 1'b1, 0});
        vecs.push_back('{1'b0, 1'b0, 9, 1'b1, 1'b1, 0});
        vecs.push_back('{1'b0, 1'b1, 1, 1'b1, 1'b1, 1});
        vecs.push_back('{1'b0, 1'b0, 9, 1'b1, 1'b1, 1});
        vecs.push_back('{1'b0, 1'b1, 1, 1'b1, 1'b1, 2});
        vecs.push_back('{1'b0, 1'b0, 79, 1'b1, 1'b1, 2});
        vecs.push_back('{1'b0, 1'b0, 1, 1'b0, 1'b1, 2});
        vecs.push_back('{1'b0, 1'b0, 99, 1'b0, 1'b1, 2});
        vecs.push_back('{1'b0, 1'b0, 1, 1'b1, 1'b1, 1});
        vecs.push_back('{1'b0, 1'b0, 99, 1'b1, 1'b1, 1});
        vecs.push_back('{1'b0, 1'b0, 1, 1'b0, 1'b1, 1});
        vecs.push_back('{1'b0, 1'b0, 100, 1'b1, 1'b1, 0});
        vecs.push_back('{1'b0, 1'b0, 100, 1'b0, 1'b1, 0});
        vecs.push_back('{1'b0, 1'b0, 100, 1'b0, 1'b0, 0});

        repeat (2) step();
        check("rst_a_pin", bus_a.o_pin, 0);
        check("rst_a_busy", bus_a.o_busy, 0);
        check("rst_a_pend", bus_a.o_pending, 0);
        check("rst_b_pin", bus_b.o_pin, 0);
        check("rst_b_pend", bus_b.o_pending, 0);
        check("rst_c_pin", bus_c.o_pin, 0);
        check("rst_c_busy", bus_c.o_busy, 0);

        foreach (vecs[i]) begin
            rst          = vecs[i].rst;
            bus_a.i_trig = vecs[i].trig;
            repeat (vecs[i].cyc) step();
            check($sformatf("vec%0d_pin", i), bus_a.o_pin, vecs[i].pin);
            check($sformatf("vec%0d_busy", i), bus_a.o_busy, vecs[i].busy);
            check($sformatf("vec%0d_pend", i), bus_a.o_pending, vecs[i].pend);
        end

        // Asynchronous reset mid-pulse with two events queued.
        bus_a.i_trig = 1'b1;
        step();
        for (int e = 1; e <= 50; e++) begin
            bus_a.i_trig = (e == 10 || e == 20);
            step();
        end
        check("arst_pre_pend", bus_a.o_pending, 2);
        check("arst_pre_pin", bus_a.o_pin, 1);
        #3;
        rst = 1'b1;
        #1;
        check("arst_pin", bus_a.o_pin, 0);
        check("arst_busy", bus_a.o_busy, 0);
        check("arst_pend", bus_a.o_pending, 0);
        step();
        rst = 1'b0;
        step();
        bus_a.i_trig = 1'b1;
        step();
        bus_a.i_trig = 1'b0;
        check("arst_fresh_rise", bus_a.o_pin, 1);
        hi_cnt = 1;
        repeat (249) begin
            step();
            hi_cnt += int'(bus_a.o_pin);
        end
        check("arst_fresh_len", hi_cnt, 100);
        check("arst_fresh_idle", bus_a.o_busy, 0);

        // Event coincident with gap expiry while one event is pending.
        for (int e = 0; e <= 199; e++) begin
            bus_a.i_trig = (e == 0 || e == 10);
            step();
        end
        check("coinc_pre_pend", bus_a.o_pending, 1);
        check("coinc_pre_pin", bus_a.o_pin, 0);
        bus_a.i_trig = 1'b1;
        step();
        bus_a.i_trig = 1'b0;
        check("coinc_pin", bus_a.o_pin, 1);
        check("coinc_pend", bus_a.o_pending, 1);
        repeat (199) step();
        check("coinc_gap2_pin", bus_a.o_pin, 0);
        check("coinc_gap2_pend", bus_a.o_pending, 1);
        step();
        check("coinc_third_pin", bus_a.o_pin, 1);
        check("coinc_third_pend", bus_a.o_pending, 0);
        repeat (200) step();
        check("coinc_idle", bus_a.o_busy, 0);

        // Zero gap: two queued pulses merge into one continuous high period.
        hi_cnt   = 0;
        fall_cnt = 0;
        last_pin = 1'b0;
        for (int e = 0; e < 300; e++) begin
            bus_c.i_trig = (e == 0 || e == 10);
            step();
            if (e == 10) check("gap0_pend1", bus_c.o_pending, 1);
            if (e == 100) begin
                check("gap0_pend0", bus_c.o_pending, 0);
                check("gap0_join_pin", bus_c.o_pin, 1);
            end
            hi_cnt += int'(bus_c.o_pin);
            if (last_pin && !bus_c.o_pin) fall_cnt++;
            last_pin = bus_c.o_pin;
        end
        check("gap0_high_len", hi_cnt, 200);
        check("gap0_falls", fall_cnt, 1);
        check("gap0_idle", bus_c.o_busy, 0);

        // Saturation with a 2-bit pending counter.
        rise_cnt = 0;
        last_pin = 1'b0;
        for (int e = 0; e <= 912; e++) begin
            bus_b.i_trig = (e <= 12) && (e % 2 == 0);
            step();
            if (e == 6) check("sat_pend_e6", bus_b.o_pending, 3);
            if (e == 12) check("sat_pend_e12", bus_b.o_pending, 3);
`ifdef IO_PULSE_OVF_EN
            if (e == 7) check("ovf_before", bus_b.o_ovf, 0);
            if (e == 8) check("ovf_set", bus_b.o_ovf, 1);
`endif
            if (bus_b.o_pin && !last_pin) rise_cnt++;
            last_pin = bus_b.o_pin;
        end
        check("sat_pulses", rise_cnt, 4);
        check("sat_idle", bus_b.o_busy, 0);
        check("sat_pend_end", bus_b.o_pending, 0);
`ifdef IO_PULSE_OVF_EN
        check("ovf_sticky", bus_b.o_ovf, 1);
        bus_b.i_ovf_clr = 1'b1;
        step();
        bus_b.i_ovf_clr = 1'b0;
        check("ovf_clr", bus_b.o_ovf, 0);
`endif

        // Randomized run against the schedule model.
        rst = 1'b1;
        bus_a.i_trig = 1'b0;
        step();
        rst        = 1'b0;
        starts.delete();
        last_start = -1000000;
        prev_trig  = 1'b0;
        n_edge     = 0;
        t_rand     = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            r_rand = ($urandom_range(0, 999) < 3);
            if ($urandom_range(0, 99) < 8) t_rand = ~t_rand;
            rst          = r_rand;
            bus_a.i_trig = t_rand;
            step();
            model_edge(r_rand, t_rand);
            check($sformatf("rnd%0d_pin", c), bus_a.o_pin, exp_on(n_edge, H));
            check($sformatf("rnd%0d_busy", c), bus_a.o_busy, exp_on(n_edge, H + G));
            check($sformatf("rnd%0d_pend", c), bus_a.o_pending, cnt_after(n_edge));
            n_edge++;
        end
        rst = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/io_pulse_stretcher.md
Name: io_pulse_stretcher

Overview:
- Output-side counterpart to the input debouncer: converts internal single-cycle event strobes into clean, human/peripheral-visible pulses on an IO pin (LED, buzzer, relay, strobe line).
- Guarantees a minimum asserted time and a minimum deasserted gap between pulses, so no glitch or sub-threshold pulse ever reaches the pad.
- Events arriving while a pulse is in progress are queued in a saturating counter and replayed in order.
- Sits between core logic and top-level output pins, on the system clock.

Parameters:
- PARAM_FREQ, 10000000, input clock frequency in Hz.
- PARAM_HOLD_MS, 10, pulse high time in ms.
- PARAM_GAP_MS, 10, minimum low time after each pulse in ms; 0 means no gap.
- PARAM_PEND_W, 4, width of the pending-event counter.

Ports:
- i_clk  input  1  system clock.
- i_rst  input  1  reset; asynchronous, active-high.
- i_trig  input  1  event request; one event per rising edge.
- o_pin  output  1  stretched pulse to the pad; registered.
- o_busy  output  1  high whenever state is not IDLE.
- o_pending  output  PARAM_PEND_W  queued events not yet emitted.

Behaviour:
- Derived cycle counts:
  - HOLD_CYC = (PARAM_FREQ/1000)*PARAM_HOLD_MS, forced to a minimum of 1.
  - GAP_CYC = (PARAM_FREQ/1000)*PARAM_GAP_MS.
  - Timing counter is 32 bits.
- Reset (asynchronous, i_rst=1):
  - o_pin=0, o_busy=0, o_pending=0, state=IDLE, timer=0, edge register i_trig_d=0.
  - o_pin drops immediately, even in the middle of a pulse.
- Event definition: i_trig=1 and i_trig_d=0, with i_trig_d registered every cycle. A trigger held high counts as one event.
- State IDLE:
  - An event moves the FSM to HOLD and loads timer=0.
  - o_pin=1 from the next clock edge, so latency is 1 cycle.
  - This event is not added to o_pending.
- State HOLD:
  - o_pin=1 for exactly HOLD_CYC cycles.
  - On expiry: go to GAP if GAP_CYC>0; otherwise go to END.
- State GAP: o_pin=0 for exactly GAP_CYC cycles, then END.
- END is a combinational decision taken in the expiry cycle, not a separate state:
  - If o_pending>0: decrement o_pending and re-enter HOLD, so o_pin rises on the next edge.
  - If o_pending=0: go to IDLE.
- With GAP_CYC=0 and pending events, o_pin stays continuously high across back-to-back pulses, with no low cycle between them.
- An event seen in HOLD or GAP increments o_pending. The counter saturates at 2^PARAM_PEND_W-1; further events are dropped.
- Event and dequeue in the same cycle: the net change to o_pending is 0. This also applies at saturation, where the new event is kept, not dropped.
- Event in the same cycle the FSM returns to IDLE: the event is counted as pending, and the FSM re-enters HOLD immediately instead of IDLE.
- o_busy=1 in HOLD and GAP; o_busy=0 only in IDLE.
- All outputs are registered; o_pin has no combinational path from i_trig.

Optional Feature:
- Macro IO_PULSE_OVF_EN.
- Defined:
  - Adds input i_ovf_clr (1 bit) and output o_ovf (1 bit, reset 0).
  - o_ovf is set on the cycle after an event is dropped at saturation.
  - o_ovf is sticky until i_ovf_clr=1 for one cycle.
  - If set and clear happen in the same cycle, set wins.
- Undefined: neither port exists; drops are silent. Behaviour is otherwise identical.

Test Plan:
All scenarios use PARAM_FREQ=100000, so 1 ms = 100 cycles; HOLD_MS=1 (100 cycles) and GAP_MS=1 (100 cycles) unless stated otherwise.
- Single 1-cycle strobe on i_trig in IDLE -> o_pin high starting exactly 1 cycle later for exactly 100 cycles. o_busy high for 200 cycles, then low. o_pending stays 0.
- Three strobes: cycle 0, then cycles 10 and 20 during HOLD -> o_pending=2, then 1, then 0. Three 100-cycle pulses, each separated by exactly 100 low cycles.
- i_trig held high for 500 cycles -> exactly one 100-cycle pulse; o_pending stays 0.
- PEND_W=2, with 6 strobes during the first HOLD -> o_pending saturates at 3; 4 pulses in total. With IO_PULSE_OVF_EN: o_ovf=1 after the 5th strobe; i_ovf_clr returns it to 0.
- Strobe coincident with GAP expiry while o_pending=1 -> o_pending stays 1 and the next HOLD starts the following cycle. GAP_MS=0 with 1 pending -> o_pin high for 200 continuous cycles.
- Assert i_rst asynchronously at HOLD cycle 50 with o_pending=2 -> o_pin=0, o_busy=0, o_pending=0 immediately. After release, a fresh strobe gives a normal 100-cycle pulse.
